// File: rtl/tff_pkg.sv
// Shared types and constants for the T-flop step controller.
package tff_pkg;

  // Default geometry of the counter bank and the step-count field
  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 8;

  // Direction encoding carried on cmd_dir
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/tff_bank.sv
// Bank of behavioural T flip-flops sharing one asynchronous clear.
module tff_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tff
    logic t_q;

    // Each flop inverts on an enabled edge and holds otherwise
    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        t_q <= 1'b0;
      end else if (t_vec[gi]) begin
        t_q <= ~t_q;
      end
    end

    assign q[gi] = t_q;
  end

endmodule

// File: rtl/tff_step_ctrl.sv
// Step sequencer driving a T-flop bank as a modulo-(limit+1) up/down counter.
module tff_step_ctrl
  import tff_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic             pause,
  output logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;

  logic [WIDTH-1:0] next_val;
  logic             step_wrap;

  // The bank is only ever driven through the toggle vector
  tff_bank #(.WIDTH(WIDTH)) u_bank (
    .clk   (clk),
    .clr   (clr),
    .t_vec (t_vec),
    .q     (q)
  );

  // Value the counter would move to on a step from the current bank output.
  // An out-of-range value (q > limit) wraps to 0 when counting up and simply
  // decrements when counting down.
  always_comb begin
    next_val  = q;
    step_wrap = 1'b0;
    if (dir_q == DIR_UP) begin
      if (q >= limit_q) begin
        next_val  = '0;
        step_wrap = 1'b1;
      end else begin
        next_val = q + WIDTH'(1);
      end
    end else begin
      if (q == '0) begin
        next_val  = limit_q;
        step_wrap = 1'b1;
      end else begin
        next_val = q - WIDTH'(1);
      end
    end
  end

  // State and command registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= IDLE;
      dir_q       <= DIR_UP;
      limit_q     <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      limit_q     <= limit_d;
      remaining_q <= remaining_d;
    end
  end

  // Next-state logic and outputs; toggles are issued only for stepping cycles
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    limit_d     = limit_q;
    remaining_d = remaining_q;
    cmd_ready   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    wrap        = 1'b0;
    t_vec       = '0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          dir_d   = cmd_dir;
          limit_d = cmd_limit;
          if (cmd_count == '0) begin
            state_d = DONE;
          end else begin
            remaining_d = cmd_count;
            state_d     = RUN;
          end
        end
      end

      RUN: begin
        busy = 1'b1;
        if (!pause) begin
          t_vec       = q ^ next_val;
          wrap        = step_wrap;
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
